// File: rtl/wb_pwm_multi_if.sv
// Wishbone B4 pipelined bus bundle for wb_pwm_multi: master drives the request
// side, slave returns registered read data and acknowledge.
interface wb_pwm_multi_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [31:0] o_wb_data;
  logic        o_wb_stall;
  logic        o_wb_ack;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_data, o_wb_stall, o_wb_ack
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_data, o_wb_stall, o_wb_ack
  );
endinterface

// File: rtl/wb_pwm_multi.sv
// Wishbone-controlled multi-channel PWM with shared prescaled period counter.
// Define WB_PWM_SYNC_UPDATE_EN to defer duty changes to period boundaries.
module wb_pwm_multi #(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst_n,
  wb_pwm_multi_if.slave       bus,
  output logic [CHANNELS-1:0] o_pwm
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic       req;
  logic       wr;
  logic [7:0] idx;
  logic       clr;
  logic       unused_ok;

  assign req       = bus.i_wb_cyc & bus.i_wb_stb;
  assign wr        = req & bus.i_wb_we;
  assign idx       = bus.i_wb_addr[7:0];
  assign clr       = wr && (idx == 8'd0) && bus.i_wb_data[2];
  assign unused_ok = ^{bus.i_wb_addr, bus.i_wb_data};

  logic                  en_q, inv_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic [WIDTH-1:0]      duty_q [CHANNELS];
  logic [WIDTH-1:0]      act_duty [CHANNELS];

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  tick;

  logic                  ack_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [CHANNELS-1:0]   pwm_q, pwm_d;

  assign tick = (pcnt_q == pre_q);

  // Bus stage: register writes and the registered read/ack land on the same edge
  always_comb begin
    rdata_d = '0;
    if (req) begin
      if (idx == 8'd0) begin
        rdata_d[2:0] = {1'b0, inv_q, en_q};
      end else if (idx == 8'd1) begin
        rdata_d[PRESCALE_W-1:0] = pre_q;
      end else begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (idx == 8'(n + 2)) rdata_d[WIDTH-1:0] = duty_q[n];
        end
      end
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      inv_q   <= 1'b0;
      pre_q   <= '0;
      for (int n = 0; n < CHANNELS; n++) duty_q[n] <= '0;
    end else begin
      ack_q   <= req;
      rdata_q <= rdata_d;
      if (wr && idx == 8'd0) begin
        en_q  <= bus.i_wb_data[0];
        inv_q <= bus.i_wb_data[1];
      end
      if (wr && idx == 8'd1) pre_q <= bus.i_wb_data[PRESCALE_W-1:0];
      for (int n = 0; n < CHANNELS; n++) begin
        if (wr && idx == 8'(n + 2)) duty_q[n] <= bus.i_wb_data[WIDTH-1:0];
      end
    end
  end

  assign bus.o_wb_ack   = ack_q;
  assign bus.o_wb_data  = rdata_q;
  assign bus.o_wb_stall = 1'b0;

  // Counter stage: CLR overrides counting, disable holds both counters at zero
  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!en_q || clr) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (tick) begin
      pcnt_d = '0;
      cnt_d  = cnt_q + WIDTH'(1);
    end else begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef WB_PWM_SYNC_UPDATE_EN
  // Shadow duty reloads only when the counter wraps, or freely while stopped
  logic [WIDTH-1:0] act_q [CHANNELS];
  logic             act_load;

  assign act_load = !en_q || (tick && (cnt_q == CNT_MAX));

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int n = 0; n < CHANNELS; n++) act_q[n] <= '0;
    end else if (act_load) begin
      for (int n = 0; n < CHANNELS; n++) act_q[n] <= duty_q[n];
    end
  end

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) act_duty[n] = act_q[n];
  end
`else
  logic unused_max;
  assign unused_max = ^CNT_MAX;

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) act_duty[n] = duty_q[n];
  end
`endif

  // Output stage: one register between the compare and the pins
  always_comb begin
    pwm_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      pwm_d[n] = (en_q && (act_duty[n] > cnt_q)) ^ inv_q;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) pwm_q <= '0;
    else             pwm_q <= pwm_d;
  end

  assign o_pwm = pwm_q;

endmodule

// File: tb/tb_wb_pwm_multi.sv
// Randomised bench for wb_pwm_multi against a time-based behavioural model.
module tb_wb_pwm_multi;
  localparam int          CH   = 3;
  localparam int          W    = 8;
  localparam int          PW   = 16;
  localparam int unsigned MAXC = 1 << W;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] pwm;

  wb_pwm_multi_if bus();

  wb_pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .bus        (bus),
    .o_pwm      (pwm)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit pwm_chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Model: counting time m_t since the counters last restarted from zero
  bit          m_en, m_inv;
  int unsigned m_pre, m_t;
  int unsigned m_pend [CH];
  int unsigned m_act  [CH];
  logic [CH-1:0] m_pwm;

  function automatic int unsigned mcnt();
    return m_en ? (m_t / (m_pre + 1)) % MAXC : 0;
  endfunction

  function automatic logic [31:0] exp_rd(input int unsigned a);
    if (a == 0) return {30'd0, m_inv, m_en};
    if (a == 1) return 32'(m_pre);
    if (a >= 2 && a < 2 + CH) return 32'(m_pend[a-2]);
    return 32'd0;
  endfunction

  task automatic mdl_reset();
    m_en = 0; m_inv = 0; m_pre = 0; m_t = 0; m_pwm = '0;
    for (int n = 0; n < CH; n++) begin
      m_pend[n] = 0;
      m_act[n]  = 0;
    end
  endtask

  task automatic mdl_step();
    int unsigned   cnt, pc, a, d;
    bit            bnd, wr, clr;
    logic [CH-1:0] p;
    cnt = mcnt();
    pc  = m_en ? m_t % (m_pre + 1) : 0;
    bnd = m_en && (pc == m_pre) && (cnt == MAXC - 1);
    for (int n = 0; n < CH; n++) p[n] = (m_en && (m_act[n] > cnt)) ^ m_inv;
    wr  = bus.i_wb_cyc && bus.i_wb_stb && bus.i_wb_we;
    a   = 32'(bus.i_wb_addr[7:0]);
    d   = bus.i_wb_data;
    clr = wr && (a == 0) && d[2];
`ifdef WB_PWM_SYNC_UPDATE_EN
    for (int n = 0; n < CH; n++) if (!m_en || bnd) m_act[n] = m_pend[n];
`else
    if (bnd) p = p;
`endif
    m_t = (!m_en || clr) ? 0 : m_t + 1;
    if (wr) begin
      if (a == 0) begin
        m_en  = d[0];
        m_inv = d[1];
      end else if (a == 1) begin
        m_pre = d % (1 << PW);
      end else if (a >= 2 && a < 2 + CH) begin
        m_pend[a-2] = d % MAXC;
      end
    end
`ifndef WB_PWM_SYNC_UPDATE_EN
    for (int n = 0; n < CH; n++) m_act[n] = m_pend[n];
`endif
    m_pwm = p;
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mdl_reset();
      else        mdl_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pwm_chk_en) check("pwm", 32'(pwm), 32'(m_pwm));
    end
  end

  task automatic wb(input bit we, input int unsigned a, input logic [31:0] d,
                    output logic [31:0] rd);
    logic [31:0] e;
    @(negedge clk);
    e = exp_rd(a);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_addr = a;
    bus.i_wb_data = d;
    @(posedge clk);
    #1;
    check("ack", 32'(bus.o_wb_ack), 32'd1);
    if (!we) check($sformatf("rd%0d", a), bus.o_wb_data, e);
    rd = bus.o_wb_data;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    @(posedge clk);
    #1;
    check("ack_idle", 32'(bus.o_wb_ack), 32'd0);
  endtask

  task automatic wait_cnt(input int unsigned c);
    for (int i = 0; i < 2000 && mcnt() != c; i++) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [CH-1:0] samp [1024];
  int cnt_hi [CH];
  int mism;

  initial begin
    bus.i_wb_cyc = 0; bus.i_wb_stb = 0; bus.i_wb_we = 0;
    bus.i_wb_addr = 0; bus.i_wb_data = 0;

    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.o_wb_ack), 32'd0);
    check("rst_data", bus.o_wb_data, 32'd0);
    check("rst_pwm", 32'(pwm), 32'd0);
    rst_n = 1'b1;
    pwm_chk_en = 1'b1;

    for (int a = 0; a <= 2 + CH; a++) begin
      wb(0, a, 0, rd);
      check("rst_rd", rd, 32'd0);
    end
    bus_idle();

    // 256-cycle period, duties 64/128/255
    wb(1, 0, 0, rd); wb(1, 1, 0, rd);
    wb(1, 2, 64, rd); wb(1, 3, 128, rd); wb(1, 4, 255, rd);
    wb(1, 0, 1, rd);
    bus_idle();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      samp[i] = pwm;
    end
    for (int n = 0; n < CH; n++) cnt_hi[n] = 0;
    for (int i = 0; i < 256; i++)
      for (int n = 0; n < CH; n++) cnt_hi[n] += int'(samp[i][n]);
    check("hi64", cnt_hi[0], 64);
    check("hi128", cnt_hi[1], 128);
    check("hi255", cnt_hi[2], 255);
    mism = 0;
    for (int i = 0; i < 256; i++) if (samp[i] !== samp[i+256]) mism++;
    check("period256", mism, 0);

    // Prescale 3: period 1024 cycles
    wb(1, 0, 0, rd); wb(1, 1, 3, rd); wb(1, 2, 2, rd); wb(1, 0, 5, rd);
    bus_idle();
    repeat (3) @(negedge clk);
    for (int n = 0; n < CH; n++) cnt_hi[n] = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      for (int n = 0; n < CH; n++) cnt_hi[n] += int'(pwm[n]);
    end
    check("pre_hi2", cnt_hi[0], 8);
    check("pre_hi128", cnt_hi[1], 512);
    check("pre_hi255", cnt_hi[2], 1020);

    // Polarity
    wb(1, 0, 0, rd); wb(1, 1, 0, rd); wb(1, 2, 0, rd); wb(1, 0, 3, rd);
    bus_idle();
    repeat (2) @(negedge clk);
    cnt_hi[0] = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt_hi[0] += int'(pwm[0]);
    end
    check("inv_duty0", cnt_hi[0], 300);
    wb(1, 0, 2, rd); bus_idle(); @(negedge clk);
    check("inv_off", 32'(pwm), 32'h7);
    wb(1, 0, 0, rd); bus_idle(); @(negedge clk);
    check("off", 32'(pwm), 32'h0);

    // Mid-period and boundary duty writes
    wb(1, 2, 200, rd); wb(1, 0, 5, rd);
    bus_idle();
    wait_cnt(99);
    wb(1, 2, 10, rd);
    bus_idle();
    repeat (300) @(negedge clk);
    wait_cnt(254);
    wb(1, 2, 180, rd);
    bus_idle();
    repeat (520) @(negedge clk);

    // Out-of-range index and CLR at cnt=77
    wb(1, 200, 32'hFFFF_FFFF, rd);
    wb(0, 200, 0, rd);
    check("oor_rd", rd, 32'd0);
    for (int a = 0; a <= 2 + CH; a++) wb(0, a, 0, rd);
    wb(1, 2, 80, rd);
    bus_idle();
    wait_cnt(76);
    wb(1, 0, 32'h5, rd);
    wb(0, 0, 0, rd);
    check("ctrl_clr", rd, 32'd1);
    bus_idle();
    repeat (100) @(negedge clk);

    // Randomised traffic
    for (int k = 0; k < 200; k++) begin
      int unsigned op, a, d;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3, 4: begin
          a = (op == 4) ? 200 : 2 + $urandom_range(0, CH);
          case ($urandom_range(0, 3))
            0: d = 0;
            1: d = MAXC - 1;
            default: d = $urandom;
          endcase
          wb(1, a, d, rd);
        end
        5: wb(0, $urandom_range(0, 7), 0, rd);
        6: wb(1, 0, $urandom, rd);
        7: begin
          wb(1, 0, 0, rd);
          wb(1, 1, $urandom_range(0, 3), rd);
          wb(1, 0, 32'h4 | ($urandom & 32'h3), rd);
        end
        8: begin
          bus_idle();
          repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        default: for (int j = 0; j < 4; j++) wb(0, $urandom_range(0, 2 + CH), 0, rd);
      endcase
    end
    bus_idle();
    repeat (50) @(negedge clk);

    // Reset while a request is in flight
    @(negedge clk);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
    bus.i_wb_addr = 0; bus.i_wb_data = 32'h3;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ack", 32'(bus.o_wb_ack), 32'd0);
    check("rst_mid_pwm", 32'(pwm), 32'd0);
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    rst_n = 1'b1;
    wb(0, 0, 0, rd);
    check("rst_mid_ctrl", rd, 32'd0);
    bus_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
